// File: rtl/colour_sequence_buffer_if.sv
// Bundle of strobes and responses between the game FSM (master)
// and the colour sequence buffer (slave).
interface colour_sequence_buffer_if #(
  parameter int unsigned COLOUR_W = 2,
  parameter int unsigned LEN_W    = 6
);
  logic                clear;
  logic                append;
  logic [COLOUR_W-1:0] new_colour;
  logic                play_start;
  logic                play_next;
  logic                play_valid;
  logic [COLOUR_W-1:0] play_colour;
  logic                play_done;
  logic                check_start;
  logic                check_valid;
  logic [COLOUR_W-1:0] check_colour;
  logic                check_match;
  logic                check_error;
  logic                check_done;
  logic [LEN_W-1:0]    length;
  logic                full;
  logic                overflow;
  logic                busy;

  modport master (
    output clear, append, new_colour, play_start, play_next, check_start, check_valid,
           check_colour,
    input  play_valid, play_colour, play_done, check_match, check_error, check_done, length,
           full, overflow, busy
  );

  modport slave (
    input  clear, append, new_colour, play_start, play_next, check_start, check_valid,
           check_colour,
    output play_valid, play_colour, play_done, check_match, check_error, check_done, length,
           full, overflow, busy
  );
endinterface

// File: rtl/colour_sequence_buffer.sv
// Simon Says colour sequence store with replay and player-check modes.
// SEQ_SHIFT_ON_FULL_EN: append while full shifts out the oldest entry instead of dropping.
module colour_sequence_buffer #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned COLOUR_W = 2,
  parameter int unsigned LEN_W    = $clog2(DEPTH + 1)
) (
  input logic                     clk,
  input logic                     reset,
  colour_sequence_buffer_if.slave bus
);
  localparam int unsigned AddrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StPlay, StCheck} state_e;

  state_e              state_q;
  logic [LEN_W-1:0]    length_q;
  logic [LEN_W-1:0]    idx_q;
  logic                overflow_q;
  logic                play_valid_q;
  logic [COLOUR_W-1:0] play_colour_q;
  logic                play_done_q;
  logic                check_match_q;
  logic                check_error_q;
  logic                check_done_q;
  logic [COLOUR_W-1:0] mem_q [DEPTH];

  logic             full;
  logic             last_entry;
  logic             append_fire;
  logic [AddrW-1:0] rd_addr;
  logic [AddrW-1:0] next_addr;
  logic [AddrW-1:0] wr_addr;

  assign full        = (length_q == LEN_W'(DEPTH));
  assign last_entry  = (idx_q == length_q - LEN_W'(1));
  assign rd_addr     = idx_q[AddrW-1:0];
  assign next_addr   = rd_addr + AddrW'(1);
  assign wr_addr     = length_q[AddrW-1:0];
  // Append only wins in IDLE when no higher-priority strobe is present.
  assign append_fire = (state_q == StIdle) && !bus.clear && !bus.play_start &&
                       !bus.check_start && bus.append;

  // Storage is never reset; entries past length are never read.
  always_ff @(posedge clk) begin
    if (reset && append_fire) begin
      if (!full) begin
        mem_q[wr_addr] <= bus.new_colour;
      end
`ifdef SEQ_SHIFT_ON_FULL_EN
      else begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          mem_q[AddrW'(i)] <= mem_q[AddrW'(i + 1)];
        end
        mem_q[AddrW'(DEPTH - 1)] <= bus.new_colour;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      length_q      <= '0;
      idx_q         <= '0;
      overflow_q    <= 1'b0;
      play_valid_q  <= 1'b0;
      play_colour_q <= '0;
      play_done_q   <= 1'b0;
      check_match_q <= 1'b0;
      check_error_q <= 1'b0;
      check_done_q  <= 1'b0;
    end else begin
      play_done_q   <= 1'b0;
      check_match_q <= 1'b0;
      check_error_q <= 1'b0;
      check_done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.clear) begin
            length_q   <= '0;
            overflow_q <= 1'b0;
          end else if (bus.play_start) begin
            if (length_q != '0) begin
              state_q       <= StPlay;
              idx_q         <= '0;
              play_valid_q  <= 1'b1;
              play_colour_q <= mem_q[0];
            end else begin
              play_done_q <= 1'b1;
            end
          end else if (bus.check_start) begin
            if (length_q != '0) begin
              state_q <= StCheck;
              idx_q   <= '0;
            end else begin
              check_done_q <= 1'b1;
            end
          end else if (bus.append) begin
            if (!full) begin
              length_q <= length_q + LEN_W'(1);
            end else begin
              overflow_q <= 1'b1;
            end
          end
        end
        StPlay: begin
          if (bus.play_next) begin
            if (last_entry) begin
              state_q      <= StIdle;
              play_valid_q <= 1'b0;
              play_done_q  <= 1'b1;
            end else begin
              idx_q         <= idx_q + LEN_W'(1);
              play_colour_q <= mem_q[next_addr];
            end
          end
        end
        StCheck: begin
          if (bus.check_valid) begin
            if (bus.check_colour == mem_q[rd_addr]) begin
              check_match_q <= 1'b1;
              if (last_entry) begin
                check_done_q <= 1'b1;
                state_q      <= StIdle;
              end else begin
                idx_q <= idx_q + LEN_W'(1);
              end
            end else begin
              check_error_q <= 1'b1;
              state_q       <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.play_valid  = play_valid_q;
  assign bus.play_colour = play_colour_q;
  assign bus.play_done   = play_done_q;
  assign bus.check_match = check_match_q;
  assign bus.check_error = check_error_q;
  assign bus.check_done  = check_done_q;
  assign bus.length      = length_q;
  assign bus.full        = full;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = (state_q != StIdle);
endmodule

// File: doc/colour_sequence_buffer.md
Name: colour_sequence_buffer

Overview:
Parametrised store for the Simon Says colour sequence. Entries are appended one per round. The block replays the stored sequence to the display path and checks player input against it, entry by entry. It sits between the colour generator and the game FSM, and adds a length counter, playback and check modes to plain sequence storage.

Parameters:
DEPTH, 32, maximum number of stored colours (2..256)
COLOUR_W, 2, bits per colour code
LEN_W, $clog2(DEPTH+1), width of length and index counters

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
clear  input  1  empty the sequence (IDLE only)
append  input  1  store new_colour at position length (IDLE only)
new_colour  input  COLOUR_W  colour to append
play_start  input  1  begin replay from entry 0
play_next  input  1  advance replay to next entry
play_valid  output  1  play_colour is valid
play_colour  output  COLOUR_W  current replay colour
play_done  output  1  one-cycle pulse after last entry is consumed
check_start  input  1  begin checking player input from entry 0
check_valid  input  1  player pressed check_colour this cycle
check_colour  input  COLOUR_W  player colour
check_match  output  1  one-cycle pulse: last press correct
check_error  output  1  one-cycle pulse: last press wrong
check_done  output  1  one-cycle pulse: whole sequence entered correctly
length  output  LEN_W  number of stored entries
full  output  1  length == DEPTH
overflow  output  1  sticky: an append was attempted while full
busy  output  1  state != IDLE

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, length=0, idx=0, overflow=0. All pulse outputs are 0, play_valid=0, play_colour=0. Storage contents need not be cleared.
- Entry 0 is the oldest colour. Entries at positions length..DEPTH-1 are don't-care and never read.
- States: IDLE, PLAY, CHECK. All outputs are registered; each response appears one cycle after its strobe.
- IDLE priority, highest first: clear, play_start, check_start, append.
  - clear: length=0, overflow=0.
  - play_start with length>0: go to PLAY, idx=0. Next cycle play_valid=1 and play_colour=mem[0].
  - play_start with length==0: play_done pulses, state stays IDLE.
  - check_start with length>0: go to CHECK, idx=0.
  - check_start with length==0: check_done pulses, state stays IDLE.
  - append when not full: mem[length]=new_colour, length+1.
  - append when full: behaviour set by Optional Feature.
- PLAY:
  - play_next with idx<length-1: idx+1, play_colour=mem[idx+1].
  - play_next with idx==length-1: play_valid=0, play_done pulses, return to IDLE.
- CHECK, on each check_valid:
  - check_colour==mem[idx] and idx<length-1: check_match pulses, idx+1.
  - Match and idx==length-1: check_match and check_done pulse in the same cycle, return to IDLE.
  - Mismatch: check_error pulses, return to IDLE. length is unchanged.
- Strobes that are not legal in the current state are ignored with no side effects: clear, append or the start strobes in PLAY or CHECK; play_next outside PLAY; check_valid outside CHECK.
- play_valid stays 1 for the whole PLAY state with no gaps.
- Reset in the middle of PLAY or CHECK aborts immediately to the reset values above.
- full and busy are combinational decodes of the registered length and state.

Optional Feature:
Macro SEQ_SHIFT_ON_FULL_EN.
- Defined: append while full drops entry 0, shifts entries 1..DEPTH-1 down by one, and writes new_colour to entry DEPTH-1. length stays DEPTH and overflow is set.
- Undefined: append while full leaves storage and length unchanged and sets overflow.

Test Plan:
- Reset, then 3 appends (1,2,3) -> length=3, full=0. play_start, then 3 play_next -> play_colour 1,2,3 on successive strobes, play_done one cycle after the third play_next, busy=0.
- Sequence 1,2,3 stored; check_start; press 1,2,3 -> check_match pulses three times, check_done on the third press, check_error never asserted.
- Sequence 1,2,3 stored; check_start; press 1,3 -> check_match, then check_error. State returns to IDLE, length remains 3.
- DEPTH=4: append 0,1,2,3 -> full=1. Append 2, macro undefined -> contents 0,1,2,3 and overflow=1. Macro defined -> contents 1,2,3,2 and overflow=1.
- Append asserted during PLAY and clear asserted during CHECK -> ignored, length unchanged. Then clear and append together in IDLE -> length=0.
- Reset driven low mid-CHECK at idx=2 -> next cycle busy=0, length=0, no pulses. play_start on the empty buffer -> immediate play_done with play_valid=0.
